// File: rtl/drbg_keystream_requester_pkg.sv
// Shared types and widths for the DRBG keystream requester and its word serializer.
package drbg_keystream_requester_pkg;

  localparam int DRBG_BLOCK_W   = 256;
  localparam int DRBG_ENTROPY_W = 256;
  localparam int RESEED_CNT_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT_REQ,
    ST_BITS_REQ,
    ST_SERVE,
    ST_GAP,
    ST_ERROR
  } state_e;

  function automatic logic [RESEED_CNT_W-1:0] sat_inc(input logic [RESEED_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/drbg_keystream_requester_serializer.sv
// Holds one captured DRBG block and streams it out LSW-first over valid/ready.
module block_word_serializer #(
  parameter int WORD_W  = 32,
  parameter int BLOCK_W = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               key_ready,
  output logic               key_valid,
  output logic [WORD_W-1:0]  key_data,
  output logic               last_accept
);

  localparam int N_WORDS = BLOCK_W / WORD_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  logic [BLOCK_W-1:0] block_q, block_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               accept;

  assign accept      = valid_q && key_ready;
  assign last_accept = accept && (idx_q == LAST_IDX);
  assign key_valid   = valid_q;
  assign key_data    = block_q[WORD_W*idx_q +: WORD_W];

  always_comb begin
    block_d = block_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      block_d = load_data;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      block_q <= block_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/drbg_keystream_requester.sv
// Drives hash-DRBG init/next_bits requests, captures each block and serves it as key words,
// with periodic reseed and a sticky stall timeout.
module drbg_keystream_requester
  import drbg_keystream_requester_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int BLOCK_W        = DRBG_BLOCK_W,
  parameter int RESEED_BLOCKS  = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DRBG_ENTROPY_W-1:0] entropy_in,
  output logic                      drbg_init,
  output logic [DRBG_ENTROPY_W-1:0] drbg_entropy,
  output logic                      drbg_next_bits,
  input  logic                      drbg_init_ready,
  input  logic                      drbg_next_bits_ready,
  input  logic [BLOCK_W-1:0]        drbg_random_bits,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic [WORD_W-1:0]         key_data,
  output logic [RESEED_CNT_W-1:0]   blocks_since_reseed,
  output logic                      busy,
  output logic                      error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                    state_q, state_d;
  logic                      init_q, init_d;
  logic                      next_bits_q, next_bits_d;
  logic [DRBG_ENTROPY_W-1:0] entropy_q, entropy_d;
  logic [RESEED_CNT_W-1:0]   blocks_q, blocks_d;
  logic                      busy_q, busy_d;
  logic                      error_q, error_d;
  logic [TMO_W-1:0]          tmo_q, tmo_d;
  logic                      init_rdy_q, init_rdy_d, init_rdy_prev_q, init_rdy_prev_d;
  logic                      bits_rdy_q, bits_rdy_d, bits_rdy_prev_q, bits_rdy_prev_d;
  logic                      init_evt, bits_evt, tmo_hit, load_block, last_accept;

  // Ready inputs are registered once, then edge-detected against their previous sample.
  assign init_evt = init_rdy_q && !init_rdy_prev_q;
  assign bits_evt = bits_rdy_q && !bits_rdy_prev_q;
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    init_rdy_d      = drbg_init_ready;
    init_rdy_prev_d = init_rdy_q;
    bits_rdy_d      = drbg_next_bits_ready;
    bits_rdy_prev_d = bits_rdy_q;
    state_d         = state_q;
    init_d          = init_q;
    next_bits_d     = next_bits_q;
    entropy_d       = entropy_q;
    blocks_d        = blocks_q;
    error_d         = error_q;
    tmo_d           = '0;
    load_block      = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_INIT_REQ;
        init_d    = 1'b1;
        entropy_d = entropy_in;
      end
      ST_INIT_REQ: begin
        if (init_evt) begin
          state_d     = ST_BITS_REQ;
          init_d      = 1'b0;
          blocks_d    = '0;
          next_bits_d = 1'b1;
        end else if (tmo_hit) begin
          state_d = ST_ERROR;
          init_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_BITS_REQ: begin
        if (bits_evt) begin
          state_d     = ST_SERVE;
          load_block  = 1'b1;
          next_bits_d = 1'b0;
          blocks_d    = sat_inc(blocks_q);
        end else if (tmo_hit) begin
          state_d     = ST_ERROR;
          next_bits_d = 1'b0;
          error_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_SERVE: if (last_accept) begin
        if (RESEED_BLOCKS != 0 && blocks_q >= RESEED_CNT_W'(RESEED_BLOCKS)) begin
          state_d   = ST_INIT_REQ;
          init_d    = 1'b1;
          entropy_d = entropy_in;
        end else begin
          state_d = ST_GAP;
        end
      end
      // One cycle with the request low so the DRBG sees a fresh rising request.
      ST_GAP: begin
        state_d     = ST_BITS_REQ;
        next_bits_d = 1'b1;
      end
      ST_ERROR: error_d = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      init_q          <= 1'b0;
      next_bits_q     <= 1'b0;
      entropy_q       <= '0;
      blocks_q        <= '0;
      busy_q          <= 1'b0;
      error_q         <= 1'b0;
      tmo_q           <= '0;
      init_rdy_q      <= 1'b0;
      init_rdy_prev_q <= 1'b0;
      bits_rdy_q      <= 1'b0;
      bits_rdy_prev_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      init_q          <= init_d;
      next_bits_q     <= next_bits_d;
      entropy_q       <= entropy_d;
      blocks_q        <= blocks_d;
      busy_q          <= busy_d;
      error_q         <= error_d;
      tmo_q           <= tmo_d;
      init_rdy_q      <= init_rdy_d;
      init_rdy_prev_q <= init_rdy_prev_d;
      bits_rdy_q      <= bits_rdy_d;
      bits_rdy_prev_q <= bits_rdy_prev_d;
    end
  end

  block_word_serializer #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W)
  ) u_serializer (
    .clk         (clk),
    .reset       (reset),
    .load        (load_block),
    .load_data   (drbg_random_bits),
    .key_ready   (key_ready),
    .key_valid   (key_valid),
    .key_data    (key_data),
    .last_accept (last_accept)
  );

  assign drbg_init           = init_q;
  assign drbg_next_bits      = next_bits_q;
  assign drbg_entropy        = entropy_q;
  assign blocks_since_reseed = blocks_q;
  assign busy                = busy_q;
  assign error               = error_q;

endmodule

// File: tb/tb_drbg_keystream_requester.sv
// Bench for drbg_keystream_requester: behavioural DRBG model plus a word-stream reference.
module tb_drbg_keystream_requester;

  localparam int WORD_W = 32;
  localparam int BLOCK_W = 256;
  localparam int RESEED = 3;
  localparam int TMO = 16;
  localparam int NW = BLOCK_W / WORD_W;
  localparam int M_NORMAL = 0, M_HOLD = 1, M_MUTE = 2;
  localparam logic [255:0] JUNK = {8{32'hDEAD_BEEF}};

  logic               clk = 1'b0;
  logic               reset, start, key_ready;
  logic [255:0]       entropy_in, drbg_entropy, drbg_random_bits;
  logic               drbg_init, drbg_next_bits, drbg_init_ready, drbg_next_bits_ready;
  logic               key_valid, busy, error;
  logic [WORD_W-1:0]  key_data;
  logic [15:0]        blocks_since_reseed;

  always #5 clk = ~clk;

  drbg_keystream_requester #(
    .WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .RESEED_BLOCKS(RESEED), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .entropy_in(entropy_in),
    .drbg_init(drbg_init), .drbg_entropy(drbg_entropy), .drbg_next_bits(drbg_next_bits),
    .drbg_init_ready(drbg_init_ready), .drbg_next_bits_ready(drbg_next_bits_ready),
    .drbg_random_bits(drbg_random_bits), .key_valid(key_valid), .key_ready(key_ready),
    .key_data(key_data), .blocks_since_reseed(blocks_since_reseed), .busy(busy), .error(error)
  );

  int errors = 0, checks = 0, cyc = 0;
  int exp_word = 0, gap_pend = 0, mode = M_NORMAL, blk_idx = 0, init_cnt = 0, nb_cnt = 0;
  bit held = 0;
  int n, nv, nb_seen, base;
  logic [255:0] e1;

  typedef struct { logic rdy; logic exp_valid; int exp_off; logic exp_nb; } bp_vec_t;
  bp_vec_t bp[15];

  function automatic logic [255:0] mk_block(input int k);
    logic [255:0] b;
    for (int i = 0; i < NW; i++) b[i*WORD_W +: WORD_W] = WORD_W'(k*NW + i);
    return b;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b, want %0b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DRBG model: init_ready after 5 cycles of init, block after 4 cycles of next_bits.
  initial begin
    drbg_init_ready = 1'b0;
    drbg_next_bits_ready = 1'b0;
    drbg_random_bits = '0;
    forever begin
      @(posedge clk); #1;
      if (drbg_init) begin
        init_cnt++;
        if (init_cnt >= 5) drbg_init_ready = 1'b1;
      end else begin
        init_cnt = 0;
        drbg_init_ready = 1'b0;
      end
      if (held) begin
        drbg_next_bits_ready = 1'b1;
        if (!drbg_next_bits) drbg_random_bits = JUNK;
      end else if (drbg_next_bits && mode != M_MUTE) begin
        nb_cnt++;
        if (nb_cnt == 4) begin
          drbg_random_bits = mk_block(blk_idx);
          blk_idx++;
          drbg_next_bits_ready = 1'b1;
          if (mode == M_HOLD) held = 1'b1;
        end
      end else begin
        nb_cnt = 0;
        drbg_next_bits_ready = 1'b0;
      end
    end
  end

  // One clock with key_ready = r; checks the word stream against consecutive integers.
  task automatic tick(input logic r);
    logic acc, last, was_valid;
    logic [255:0] ent;
    bit reseed;
    key_ready = r;
    acc = key_valid && r;
    was_valid = key_valid;
    check1("req_while_valid", drbg_next_bits && key_valid, 1'b0);
    if (key_valid)
      check("blocks_in_serve", 256'(blocks_since_reseed), 256'((exp_word / NW) % RESEED + 1));
    if (acc) check("key_word", 256'(key_data), 256'(exp_word));
    last = acc && (exp_word % NW == NW - 1);
    if (acc) exp_word++;
    ent = entropy_in;
    @(posedge clk); @(negedge clk);
    cyc++;
    if (gap_pend != 0) begin
      check1("gap_then_req", drbg_next_bits, 1'b1);
      gap_pend = 0;
    end
    if (was_valid && !last) check1("valid_mid_block", key_valid, 1'b1);
    if (last) begin
      reseed = (exp_word % (NW*RESEED) == 0);
      check1("reinit_after_block", drbg_init, reseed);
      if (reseed) check("reseed_entropy", drbg_entropy, ent);
      else begin
        check1("gap_req_low", drbg_next_bits, 1'b0);
        check1("gap_valid_low", key_valid, 1'b0);
        gap_pend = 1;
      end
    end
  endtask

  task automatic do_reset(input int m);
    @(negedge clk);
    reset = 1'b1; start = 1'b0; key_ready = 1'b0;
    mode = m; held = 1'b0; blk_idx = 0; exp_word = 0; gap_pend = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input logic r, input string name);
    int k = 0;
    while (!key_valid && k < 60) begin tick(r); k++; end
    check1(name, key_valid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    bp[0]  = '{1'b1, 1'b1, 0, 1'b0};
    bp[1]  = '{1'b0, 1'b1, 1, 1'b0};
    bp[2]  = '{1'b0, 1'b1, 1, 1'b0};
    bp[3]  = '{1'b1, 1'b1, 1, 1'b0};
    bp[4]  = '{1'b1, 1'b1, 2, 1'b0};
    bp[5]  = '{1'b0, 1'b1, 3, 1'b0};
    bp[6]  = '{1'b0, 1'b1, 3, 1'b0};
    bp[7]  = '{1'b1, 1'b1, 3, 1'b0};
    bp[8]  = '{1'b1, 1'b1, 4, 1'b0};
    bp[9]  = '{1'b0, 1'b1, 5, 1'b0};
    bp[10] = '{1'b0, 1'b1, 5, 1'b0};
    bp[11] = '{1'b1, 1'b1, 5, 1'b0};
    bp[12] = '{1'b1, 1'b1, 6, 1'b0};
    bp[13] = '{1'b0, 1'b1, 7, 1'b0};
    bp[14] = '{1'b1, 1'b1, 7, 1'b0};

    reset = 1'b1; start = 1'b0; key_ready = 1'b0; entropy_in = '0;
    do_reset(M_NORMAL);

    // Reset state
    check1("rst_init", drbg_init, 1'b0);
    check1("rst_next_bits", drbg_next_bits, 1'b0);
    check1("rst_valid", key_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_error", error, 1'b0);
    check("rst_entropy", drbg_entropy, '0);
    check("rst_key_data", 256'(key_data), '0);
    check("rst_blocks", 256'(blocks_since_reseed), '0);
    repeat (2) tick(1'b1);
    check1("idle_stays_idle", busy, 1'b0);

    // Basic flow
    e1 = rand256();
    entropy_in = e1;
    start = 1'b1; tick(1'b1); start = 1'b0;
    check1("init_on_start", drbg_init, 1'b1);
    check("entropy_latched", drbg_entropy, e1);
    check1("busy_after_start", busy, 1'b1);
    entropy_in = rand256();
    n = 0;
    while (drbg_init && n < 40) begin tick(1'b1); n++; end
    check1("init_dropped_on_ready", drbg_init, 1'b0);
    check("blocks_after_init", 256'(blocks_since_reseed), '0);
    check1("bits_req_after_init", drbg_next_bits, 1'b1);
    n = 0; nb_seen = -1;
    while (!key_valid && n < 40) begin
      if (drbg_next_bits_ready && nb_seen < 0) nb_seen = cyc;
      tick(1'b1); n++;
    end
    check1("first_valid", key_valid, 1'b1);
    check("first_valid_latency", 256'(cyc - nb_seen), 256'(2));
    check("first_word", 256'(key_data), '0);

    // Reseed after three blocks
    n = 0;
    while (exp_word < NW*RESEED && n < 200) begin tick(1'b1); n++; end
    check1("valid_low_in_reinit", key_valid, 1'b0);
    n = 0;
    while (drbg_init && n < 40) begin tick(1'b0); n++; end
    check1("reinit_answered", drbg_init, 1'b0);
    check("blocks_cleared_on_reinit", 256'(blocks_since_reseed), '0);
    wait_valid(1'b0, "valid_after_reseed");
    check("blocks_after_reseed_block", 256'(blocks_since_reseed), 256'(1));

    // Backpressure table
    base = exp_word;
    for (int i = 0; i < 15; i++) begin
      check1($sformatf("bp_valid[%0d]", i), key_valid, bp[i].exp_valid);
      check($sformatf("bp_data[%0d]", i), 256'(key_data), 256'(base + bp[i].exp_off));
      check1($sformatf("bp_req[%0d]", i), drbg_next_bits, bp[i].exp_nb);
      tick(bp[i].rdy);
    end
    check("bp_words_consumed", 256'(exp_word), 256'(base + NW));

    // Randomised run with random backpressure, entropy and stray start pulses
    base = exp_word;
    for (int i = 0; i < 600; i++) begin
      entropy_in = rand256();
      start = ($urandom_range(0, 15) == 0);
      tick($urandom_range(0, 99) < 65);
    end
    start = 1'b0;
    check1("random_progress", (exp_word - base) > 80, 1'b1);
    check1("random_no_error", error, 1'b0);

    // Ready held high: no second capture without a fresh edge
    do_reset(M_HOLD);
    start = 1'b1; tick(1'b1); start = 1'b0;
    n = 0;
    while (exp_word < NW && n < 80) begin tick(1'b1); n++; end
    check("hold_first_block", 256'(exp_word), 256'(NW));
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      if (key_valid) nv++;
      tick(1'b1);
    end
    check("no_capture_on_level", 256'(nv), '0);

    // Timeout in BITS_REQ
    do_reset(M_MUTE);
    start = 1'b1; tick(1'b0); start = 1'b0;
    n = 0;
    while (!drbg_next_bits && n < 40) begin tick(1'b0); n++; end
    check1("tmo_req_raised", drbg_next_bits, 1'b1);
    repeat (TMO - 1) tick(1'b0);
    check1("tmo_not_yet", error, 1'b0);
    check1("tmo_req_still_high", drbg_next_bits, 1'b1);
    tick(1'b0);
    check1("tmo_error_set", error, 1'b1);
    check1("tmo_nb_low", drbg_next_bits, 1'b0);
    check1("tmo_init_low", drbg_init, 1'b0);
    start = 1'b1; tick(1'b0); start = 1'b0;
    repeat (3) tick(1'b0);
    check1("error_sticky", error, 1'b1);
    check1("error_start_ignored", drbg_init, 1'b0);
    check1("error_busy", busy, 1'b1);

    // Asynchronous reset mid-SERVE
    do_reset(M_NORMAL);
    start = 1'b1; tick(1'b1); start = 1'b0;
    n = 0;
    while (!(key_valid && exp_word == 3) && n < 80) begin tick(1'b1); n++; end
    check("serve_reached_word3", 256'(key_data), 256'(3));
    #1 reset = 1'b1;
    #1;
    check1("async_rst_valid", key_valid, 1'b0);
    check1("async_rst_busy", busy, 1'b0);
    check1("async_rst_next_bits", drbg_next_bits, 1'b0);
    check1("async_rst_init", drbg_init, 1'b0);
    repeat (2) @(negedge clk);
    exp_word = 0; blk_idx = 0; gap_pend = 0; key_ready = 1'b0;
    reset = 1'b0;
    start = 1'b1; tick(1'b1); start = 1'b0;
    check1("reinit_after_reset", drbg_init, 1'b1);
    n = 0;
    while (exp_word < NW && n < 80) begin tick(1'b1); n++; end
    check("restart_block_served", 256'(exp_word), 256'(NW));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
